// File: rtl/ps2kb_fifo_ctrl.sv
// ps2kb_fifo_ctrl: PS/2 keyboard receiver with a first-word-fall-through result FIFO.
//   Synchronises the PS/2 pins, deserialises 11-bit frames on falling device-clock edges,
//   checks parity, start, stop and inter-edge timeout, optionally folds E0/F0 prefixes into
//   flag bits, and queues {code, break, extended} entries for the host.
// Ports:
//   i_clock, i_reset          system clock, asynchronous active-high reset
//   i_device_clock/_data      raw PS/2 pins (asynchronous)
//   i_fifo_pop                pulse: discard head entry (ignored when empty)
//   i_clear_error             pulse: clear sticky o_frame_error and o_overflow
//   o_irq                     FIFO non-empty
//   o_keycode/o_key_break/o_key_extended  head entry (zero when empty)
//   o_fifo_count              entries held, 0..FIFO_DEPTH
//   o_frame_error, o_overflow sticky status
module ps2kb_fifo_ctrl #(
  parameter logic [15:0] OVER_TIME  = 16'd1000,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter bit          COOKED     = 1'b1
) (
  input  logic                          i_clock,
  input  logic                          i_reset,
  input  logic                          i_device_clock,
  input  logic                          i_device_data,
  input  logic                          i_fifo_pop,
  input  logic                          i_clear_error,
  output logic                          o_irq,
  output logic [7:0]                    o_keycode,
  output logic                          o_key_break,
  output logic                          o_key_extended,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count,
  output logic                          o_frame_error,
  output logic                          o_overflow
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FullCount = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StRecv, StCheck} state_e;

  // Pin synchronisers; reset high so the idle bus produces no spurious edge.
  logic [1:0] r_dclk_s, r_ddat_s;
  logic       r_dclk_prev;
  logic       w_fall;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_dclk_s    <= 2'b11;
      r_ddat_s    <= 2'b11;
      r_dclk_prev <= 1'b1;
    end else begin
      r_dclk_s    <= {r_dclk_s[0], i_device_clock};
      r_ddat_s    <= {r_ddat_s[0], i_device_data};
      r_dclk_prev <= r_dclk_s[1];
    end
  end

  assign w_fall = r_dclk_prev & ~r_dclk_s[1];

  // Receiver
  state_e      r_state;
  logic [9:0]  r_shift;     // after 10 shifts: [7:0] data, [8] parity, [9] stop
  logic [3:0]  r_bitcnt;
  logic [15:0] r_timer;
  logic        r_brk_pend, r_ext_pend;

  logic        w_timeout, w_frame_ok, w_is_prefix, w_err;
  logic        w_push;
  logic [9:0]  w_push_data;  // {brk, ext, code}

  assign w_timeout   = (r_state == StRecv) && !w_fall && (r_timer == OVER_TIME - 16'd1);
  assign w_frame_ok  = (^r_shift[8:0]) && r_shift[9];
  assign w_is_prefix = COOKED && ((r_shift[7:0] == 8'hE0) || (r_shift[7:0] == 8'hF0));
  assign w_err       = w_timeout || ((r_state == StCheck) && !w_frame_ok);

  always_comb begin
    w_push      = 1'b0;
    w_push_data = {2'b00, 8'hFF};
    if (w_err) begin
      w_push = 1'b1;
    end else if (r_state == StCheck && !w_is_prefix) begin
      w_push      = 1'b1;
      w_push_data = {COOKED & r_brk_pend, COOKED & r_ext_pend, r_shift[7:0]};
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= StIdle;
      r_shift    <= '0;
      r_bitcnt   <= '0;
      r_timer    <= '0;
      r_brk_pend <= 1'b0;
      r_ext_pend <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_fall && !r_ddat_s[1]) begin
            r_state  <= StRecv;
            r_bitcnt <= '0;
            r_timer  <= '0;
          end
        end
        StRecv: begin
          if (w_fall) begin
            r_shift <= {r_ddat_s[1], r_shift[9:1]};
            r_timer <= '0;
            if (r_bitcnt == 4'd9) r_state  <= StCheck;
            else                  r_bitcnt <= r_bitcnt + 4'd1;
          end else if (w_timeout) begin
            r_state    <= StIdle;
            r_brk_pend <= 1'b0;
            r_ext_pend <= 1'b0;
          end else begin
            r_timer <= r_timer + 16'd1;
          end
        end
        StCheck: begin
          r_state <= StIdle;
          if (!w_frame_ok || !COOKED) begin
            r_brk_pend <= 1'b0;
            r_ext_pend <= 1'b0;
          end else if (r_shift[7:0] == 8'hE0) begin
            r_ext_pend <= 1'b1;
          end else if (r_shift[7:0] == 8'hF0) begin
            r_brk_pend <= 1'b1;
          end else begin
            r_brk_pend <= 1'b0;
            r_ext_pend <= 1'b0;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // FIFO
  logic [9:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_count;
  logic          r_frame_error, r_overflow;
  logic          w_empty, w_full, w_pop, w_wr, w_drop;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == FullCount);
  assign w_pop   = i_fifo_pop && !w_empty;
  // When full, a simultaneous pop frees the slot the write lands in.
  assign w_wr    = w_push && (!w_full || w_pop);
  assign w_drop  = w_push && w_full && !w_pop;

  always_ff @(posedge i_clock) begin
    if (w_wr) r_mem[r_wptr] <= w_push_data;
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_wptr        <= '0;
      r_rptr        <= '0;
      r_count       <= '0;
      r_frame_error <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      if (w_wr)  r_wptr <= r_wptr + AW'(1);
      if (w_pop) r_rptr <= r_rptr + AW'(1);
      if (w_wr && !w_pop)      r_count <= r_count + (AW + 1)'(1);
      else if (!w_wr && w_pop) r_count <= r_count - (AW + 1)'(1);
      // A new event in the same cycle as clear keeps the flag set.
      if (w_err)              r_frame_error <= 1'b1;
      else if (i_clear_error) r_frame_error <= 1'b0;
      if (w_drop)             r_overflow <= 1'b1;
      else if (i_clear_error) r_overflow <= 1'b0;
    end
  end

  logic [9:0] w_head;
  assign w_head = w_empty ? 10'd0 : r_mem[r_rptr];

  assign o_irq          = !w_empty;
  assign o_keycode      = w_head[7:0];
  assign o_key_extended = w_head[8];
  assign o_key_break    = w_head[9];
  assign o_fifo_count   = r_count;
  assign o_frame_error  = r_frame_error;
  assign o_overflow     = r_overflow;

endmodule

// File: tb/tb_ps2kb_fifo_ctrl.sv
// Bench: one cooked and one raw instance share the PS/2 pins; each has its own expected queue.
module tb_ps2kb_fifo_ctrl;

  localparam int unsigned Depth = 4;
  localparam logic [15:0] OverTime = 16'd200;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic dc = 1'b1, dd = 1'b1;
  logic pop_c = 1'b0, pop_r = 1'b0, clr = 1'b0;

  logic       c_irq, c_brk, c_ext, c_ferr, c_ovf;
  logic [7:0] c_code;
  logic [2:0] c_cnt;
  logic       r_irq, r_brk, r_ext, r_ferr, r_ovf;
  logic [7:0] r_code;
  logic [2:0] r_cnt;

  always #5 clk = ~clk;

  ps2kb_fifo_ctrl #(.OVER_TIME(OverTime), .FIFO_DEPTH(Depth), .COOKED(1'b1)) dut_c (
    .i_clock(clk), .i_reset(rst), .i_device_clock(dc), .i_device_data(dd),
    .i_fifo_pop(pop_c), .i_clear_error(clr), .o_irq(c_irq), .o_keycode(c_code),
    .o_key_break(c_brk), .o_key_extended(c_ext), .o_fifo_count(c_cnt),
    .o_frame_error(c_ferr), .o_overflow(c_ovf)
  );

  ps2kb_fifo_ctrl #(.OVER_TIME(OverTime), .FIFO_DEPTH(Depth), .COOKED(1'b0)) dut_r (
    .i_clock(clk), .i_reset(rst), .i_device_clock(dc), .i_device_data(dd),
    .i_fifo_pop(pop_r), .i_clear_error(clr), .o_irq(r_irq), .o_keycode(r_code),
    .o_key_break(r_brk), .o_key_extended(r_ext), .o_fifo_count(r_cnt),
    .o_frame_error(r_ferr), .o_overflow(r_ovf)
  );

  int n_vec = 0;
  int n_bad = 0;
  logic [9:0] q_c[$];  // expected {brk, ext, code}
  logic [9:0] q_r[$];

  typedef struct {
    logic [7:0] data;
    bit         bad;
    bit         push;
    logic [7:0] code;
    bit         brk;
    bit         ext;
    bit         ferr;
  } vec_t;
  vec_t tbl[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drive the first nbits of a frame (start, 8 data LSB first, odd parity, stop).
  task automatic send_bits(input logic [7:0] d, input bit bad, input int nbits);
    logic [10:0] f;
    f = {1'b1, (~^d) ^ bad, d, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      dd = f[i];
      repeat (10) @(posedge clk);
      dc = 1'b0;
      repeat (10) @(posedge clk);
      dc = 1'b1;
    end
    repeat (10) @(posedge clk);
  endtask

  task automatic pulse_clear();
    @(negedge clk) clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
  endtask

  task automatic push_both(input logic [9:0] c, input logic [9:0] r);
    if (q_c.size() < Depth) q_c.push_back(c);
    if (q_r.size() < Depth) q_r.push_back(r);
  endtask

  task automatic drain(input bit raw);
    int n;
    logic [9:0] exp;
    n = raw ? q_r.size() : q_c.size();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      exp = raw ? q_r.pop_front() : q_c.pop_front();
      if (raw) begin
        check("raw_head", {r_brk, r_ext, r_code}, exp);
        check("raw_irq", r_irq, 1);
        pop_r = 1'b1;
      end else begin
        check("cooked_head", {c_brk, c_ext, c_code}, exp);
        check("cooked_irq", c_irq, 1);
        pop_c = 1'b1;
      end
      @(posedge clk);
      #1 pop_r = 1'b0;
      pop_c = 1'b0;
    end
    @(negedge clk);
    if (raw) check("raw_empty", {r_irq, r_cnt, r_code}, 0);
    else     check("cooked_empty", {c_irq, c_cnt, c_code}, 0);
  endtask

  initial begin
    tbl[0]  = '{8'h1C, 1'b0, 1'b1, 8'h1C, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{8'hE0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{8'hF0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{8'h75, 1'b0, 1'b1, 8'h75, 1'b1, 1'b1, 1'b0};
    tbl[4]  = '{8'h1C, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b1};
    tbl[5]  = '{8'hE0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{8'h1C, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b1};
    tbl[7]  = '{8'h5A, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{8'hF0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{8'hAA, 1'b0, 1'b1, 8'hAA, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{8'hFA, 1'b0, 1'b1, 8'hFA, 1'b0, 1'b0, 1'b0};

    repeat (3) @(negedge clk);
    check("reset_cooked", {c_irq, c_code, c_brk, c_ext, c_cnt, c_ferr, c_ovf}, 0);
    check("reset_raw", {r_irq, r_code, r_brk, r_ext, r_cnt, r_ferr, r_ovf}, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Table-driven frames
    for (int v = 0; v < 11; v++) begin
      send_bits(tbl[v].data, tbl[v].bad, 11);
      if (tbl[v].push) q_c.push_back({tbl[v].brk, tbl[v].ext, tbl[v].code});
      q_r.push_back({2'b00, tbl[v].bad ? 8'hFF : tbl[v].data});
      @(negedge clk);
      check("cooked_count", c_cnt, q_c.size());
      check("raw_count", r_cnt, q_r.size());
      check("cooked_ferr", c_ferr, tbl[v].ferr);
      check("raw_ferr", r_ferr, tbl[v].ferr);
      drain(1'b0);
      drain(1'b1);
      if (tbl[v].ferr) begin
        pulse_clear();
        @(negedge clk);
        check("ferr_cleared", {c_ferr, r_ferr}, 0);
      end
    end

    // Timeout after 5 data bits, then a normal frame
    send_bits(8'h00, 1'b0, 6);
    repeat (OverTime + 100) @(posedge clk);
    push_both({2'b00, 8'hFF}, {2'b00, 8'hFF});
    @(negedge clk);
    check("timeout_ferr", {c_ferr, r_ferr}, 2'b11);
    check("timeout_count", {c_cnt, r_cnt}, {3'd1, 3'd1});
    send_bits(8'h1C, 1'b0, 11);
    push_both({2'b00, 8'h1C}, {2'b00, 8'h1C});
    drain(1'b0);
    drain(1'b1);
    pulse_clear();

    // Overflow: Depth+1 frames with no pop; last one dropped
    for (int i = 0; i <= Depth; i++) begin
      send_bits(8'h10 + 8'(i), 1'b0, 11);
      push_both({2'b00, 8'h10 + 8'(i)}, {2'b00, 8'h10 + 8'(i)});
    end
    @(negedge clk);
    check("ovf_count", {c_cnt, r_cnt}, {3'(Depth), 3'(Depth)});
    check("ovf_flag", {c_ovf, r_ovf}, 2'b11);
    check("ovf_no_ferr", {c_ferr, r_ferr}, 0);
    drain(1'b0);
    drain(1'b1);
    pulse_clear();
    @(negedge clk);
    check("ovf_cleared", {c_ovf, r_ovf}, 0);
    // Pop while empty is ignored
    pop_c = 1'b1;
    @(posedge clk);
    #1 pop_c = 1'b0;
    @(negedge clk);
    check("pop_empty", {c_cnt, c_irq}, 0);

    // Raw F0,1C then reset mid-frame
    send_bits(8'hF0, 1'b0, 11);
    send_bits(8'h1C, 1'b0, 11);
    @(negedge clk);
    check("raw_two", r_cnt, 2);
    check("raw_first", r_code, 8'hF0);
    check("cooked_one", {c_cnt, c_brk, c_code}, {3'd1, 1'b1, 8'h1C});
    send_bits(8'h55, 1'b0, 4);
    @(negedge clk) rst = 1'b1;
    #1;
    check("midrst_cooked", {c_irq, c_code, c_brk, c_ext, c_cnt, c_ferr, c_ovf}, 0);
    check("midrst_raw", {r_irq, r_code, r_brk, r_ext, r_cnt, r_ferr, r_ovf}, 0);
    q_c.delete();
    q_r.delete();
    dd = 1'b1;
    @(negedge clk) rst = 1'b0;
    repeat (3) @(posedge clk);
    send_bits(8'h44, 1'b0, 11);
    push_both({2'b00, 8'h44}, {2'b00, 8'h44});
    drain(1'b0);
    drain(1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
